frac_int_divider: RTL and testbench
===================================

# frac_int_divider

Sequential shift-subtract divider that recovers an 8-bit unsigned integer from a Q8.16 product and its Q0.16 fraction factor: q = p / b. It sits on the decode/dequantisation side of the image-compression datapath, opposite the combinational 8x16 integer-by-fraction multiplier. It produces one quotient bit per cycle behind valid/ready handshakes on both sides.

## Interface
- ROUND, default 0: 0 = truncate quotient; 1 = round half up, saturating at 255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_p  in  24  dividend, unsigned Q8.16
- in_b  in  16  divisor, unsigned Q0.16
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_q  out  8  quotient, unsigned integer
- out_rem  out  16  final remainder, Q0.16 units, pre-rounding
- out_ovf  out  1  true quotient > 255 (out_q saturated)
- out_dz  out  1  in_b was zero

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_p into rem (24 b) and in_b into div.
  - If in_b==0: out_q=255, out_rem=0, out_dz=1, out_ovf=0; go to DONE.
  - Else if in_p >= in_b<<8 (26-bit compare): out_q=255, out_rem=0, out_ovf=1, out_dz=0; go to DONE.
  - Else: clear quotient, cnt=7, go to CALC.
- CALC, one step per cycle for bit i=cnt: if rem >= (div<<i), then rem -= div<<i and q[i]=1. Use 24-bit compare/subtract with no truncation of div<<i. On cnt==0, go to DONE; otherwise cnt decrements.
- Rounding is applied on the CALC to DONE edge when ROUND=1: if 2*rem >= div (17-bit compare) and q!=255, then q+1. out_rem always reports the unrounded remainder, which is < div and fits 16 b.
- DONE: out_valid=1. Outputs stay stable until out_valid&out_ready, then go to IDLE. in_ready=0 in CALC and DONE; no overlap between operations.
- Flags are mutually exclusive. out_dz takes priority over out_ovf.
- in_valid outside IDLE is ignored. Operands must not be sampled except on the accept edge.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_q=0, out_rem=0, out_ovf=0, out_dz=0, cnt=0.
- Normal path: accept at edge N; CALC steps at edges N+1..N+8; out_valid is high from edge N+8. Accept-to-valid latency is 8 cycles.
- Overflow or zero-divisor path: out_valid is high from edge N+1, a latency of 1 cycle.
- Throughput: with out_ready held high, one result every 10 cycles on the normal path. The cycle sequence is accept, 8 CALC, DONE handshake, then IDLE for 1 cycle before the next accept.
- Result handshake at edge M: in_ready is high from edge M and out_valid is low from edge M.
- An rst_n assertion at any point, mid-CALC included, immediately returns every output to its reset value. Any in-flight operation is discarded without a result.
- Result registers are not altered after DONE until the next accept.

## Structure
- Shared package holds the width constants: P_W=24, B_W=16, Q_W=8, FRAC_BITS=16. It also holds the state enumeration (IDLE, CALC, DONE).
- One sub-module is natural: frac_div_step. It is combinational and takes rem, div and shift i. It returns the next rem and the quotient bit. It is instantiated once and reused each CALC cycle.
- Controller, counter, pre-checks and rounding live in the top module.

## Test plan
- p=0x050000, b=0x8000 (5.0/0.5) -> q=10, rem=0, ovf=0, dz=0, out_valid exactly 8 cycles after accept.
- p=0xFEFF01, b=0xFFFF (255x0.99998) -> q=255, rem=0, ovf=0. p=0x050001, b=0x8000 -> q=10, rem=1.
- p=0x800000, b=0x8000 -> q=255, ovf=1, rem=0, latency 1. b=0x0000 with any p -> q=255, dz=1, ovf=0.
- ROUND=1: p=0x04C000, b=0x8000 (9.5) -> q=10, rem=0x4000. The same operands with ROUND=0 -> q=9.
- Backpressure: hold out_ready low 5 cycles after out_valid. Outputs must stay stable, in_ready must stay 0, and toggling in_valid/in_p must have no effect. Release out_ready: in_ready is high on the next cycle.
- Pulse rst_n low during CALC cycle 4 -> all outputs take reset values at once. A fresh operation, 0x050000 / 0x8000, then returns q=10 normally.

Source files
------------

// File: rtl/frac_int_divider_pkg.sv
// Shared widths and controller state encoding for the Q8.16 / Q0.16 divider.
package frac_int_divider_pkg;
  localparam int unsigned P_W       = 24;
  localparam int unsigned B_W       = 16;
  localparam int unsigned Q_W       = 8;
  localparam int unsigned FRAC_BITS = 16;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/frac_div_step.sv
// One restoring shift-subtract step: compares rem against div<<shift at full width.
module frac_div_step
  import frac_int_divider_pkg::*;
(
  input  logic [P_W-1:0]   rem,
  input  logic [B_W-1:0]   div,
  input  logic [CNT_W-1:0] shift,
  output logic [P_W-1:0]   rem_next,
  output logic             qbit
);
  logic [P_W-1:0] div_sh;

  always_comb begin
    div_sh   = P_W'(div) << shift;
    qbit     = (rem >= div_sh);
    rem_next = qbit ? (rem - div_sh) : rem;
  end
endmodule

// File: rtl/frac_int_divider.sv
// Sequential divider q = p / b (Q8.16 / Q0.16 -> 8-bit integer), one quotient bit per cycle.
module frac_int_divider
  import frac_int_divider_pkg::*;
#(
  parameter bit ROUND = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [P_W-1:0] in_p,
  input  logic [B_W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Q_W-1:0] out_q,
  output logic [B_W-1:0] out_rem,
  output logic           out_ovf,
  output logic           out_dz
);
  state_t           state, state_nxt;
  logic [P_W-1:0]   rem;
  logic [B_W-1:0]   div;
  logic [Q_W-1:0]   q;
  logic [CNT_W-1:0] cnt;
  logic             ovf, dz, early;

  logic             accept;
  logic             in_ovf;
  logic [P_W-1:0]   rem_step;
  logic             qbit;
  logic [Q_W-1:0]   q_bits;
  logic             round_up;

  frac_div_step u_step (
    .rem      (rem),
    .div      (div),
    .shift    (cnt),
    .rem_next (rem_step),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = in_valid && (state == IDLE);
    in_ovf   = ({2'b00, in_p} >= {2'b00, in_b, 8'h00});
    q_bits   = q | (Q_W'(qbit) << cnt);
    round_up = ROUND && ({rem_step[B_W-1:0], 1'b0} >= {1'b0, div}) && (q_bits != '1);
  end

  // Zero-divisor/overflow results are final at accept; they spend one CALC slot
  // (early=1, cnt=0) without touching the datapath so they surface after one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      div   <= '0;
      q     <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
      early <= 1'b0;
    end else if (accept) begin
      div <= in_b;
      if (in_b == '0) begin
        q     <= '1;
        rem   <= '0;
        dz    <= 1'b1;
        ovf   <= 1'b0;
        early <= 1'b1;
        cnt   <= '0;
      end else if (in_ovf) begin
        q     <= '1;
        rem   <= '0;
        dz    <= 1'b0;
        ovf   <= 1'b1;
        early <= 1'b1;
        cnt   <= '0;
      end else begin
        q     <= '0;
        rem   <= in_p;
        dz    <= 1'b0;
        ovf   <= 1'b0;
        early <= 1'b0;
        cnt   <= CNT_W'(Q_W - 1);
      end
    end else if ((state == CALC) && !early) begin
      rem <= rem_step;
      if (cnt == '0) begin
        q <= q_bits + Q_W'(round_up);
      end else begin
        q   <= q_bits;
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    out_q   = q;
    out_rem = rem[B_W-1:0];
    out_ovf = ovf;
    out_dz  = dz;
  end
endmodule

// File: tb/tb_frac_int_divider.sv
// Directed and randomized checks of frac_int_divider (ROUND=0 and ROUND=1 instances in lockstep).
module tb_frac_int_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_p = '0;
  logic [15:0] in_b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, ovf0, dz0;
  logic [7:0]  q0;
  logic [15:0] rem0;
  logic        in_ready1, out_valid1, ovf1, dz1;
  logic [7:0]  q1;
  logic [15:0] rem1;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  frac_int_divider #(.ROUND(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_p(in_p), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
    .out_q(q0), .out_rem(rem0), .out_ovf(ovf0), .out_dz(dz0)
  );

  frac_int_divider #(.ROUND(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_p(in_p), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
    .out_q(q1), .out_rem(rem1), .out_ovf(ovf1), .out_dz(dz1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division of the raw codes (the 2^16 scales cancel).
  task automatic model(input logic [23:0] p, input logic [15:0] b, input bit rnd,
                       output logic [7:0] q, output logic [15:0] r,
                       output logic ovf, output logic dz, output int lat);
    int unsigned qt, rt;
    if (b == 0) begin
      q = 8'd255; r = '0; ovf = 1'b0; dz = 1'b1; lat = 1;
    end else begin
      qt = int'(p) / int'(b);
      rt = int'(p) % int'(b);
      dz = 1'b0;
      if (qt > 255) begin
        q = 8'd255; r = '0; ovf = 1'b1; lat = 1;
      end else begin
        ovf = 1'b0; lat = 8; r = rt[15:0];
        if (rnd && (2 * rt >= int'(b)) && qt != 255) qt = qt + 1;
        q = qt[7:0];
      end
    end
  endtask

  task automatic chk_res(input string tag,
                         input logic [7:0] eq0, input logic [7:0] eq1, input logic [15:0] er,
                         input logic eovf, input logic edz);
    chk({tag, ".q0"},   q0,   eq0);
    chk({tag, ".q1"},   q1,   eq1);
    chk({tag, ".rem0"}, rem0, er);
    chk({tag, ".rem1"}, rem1, er);
    chk({tag, ".ovf"},  {ovf0, ovf1}, {eovf, eovf});
    chk({tag, ".dz"},   {dz0, dz1},   {edz, edz});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ready"}, {in_ready0, in_ready1}, 2'b11);
    chk({tag, ".valid"}, {out_valid0, out_valid1}, 2'b00);
    chk_res(tag, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [23:0] p, input logic [15:0] b,
                        input int bp_cycles);
    logic [7:0]  eq0, eq1;
    logic [15:0] er;
    logic        eovf, edz;
    int          elat, lat;
    model(p, b, 1'b0, eq0, er, eovf, edz, elat);
    model(p, b, 1'b1, eq1, er, eovf, edz, elat);

    @(negedge clk);
    in_p = p; in_b = b; in_valid = 1'b1;
    chk({tag, ".idle_ready"}, {in_ready0, in_ready1}, 2'b11);
    @(posedge clk); #1;
    in_valid = 1'b0; in_p = 24'($urandom); in_b = 16'($urandom);
    chk({tag, ".busy_ready"}, {in_ready0, in_ready1}, 2'b00);

    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid0) break;
    end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".valid1"}, out_valid1, 1'b1);
    chk_res(tag, eq0, eq1, er, eovf, edz);

    for (int i = 0; i < bp_cycles; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; in_p = 24'($urandom); in_b = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, ".bp_valid"}, {out_valid0, out_valid1}, 2'b11);
      chk({tag, ".bp_ready"}, {in_ready0, in_ready1}, 2'b00);
      chk_res({tag, ".bp"}, eq0, eq1, er, eovf, edz);
    end

    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".hs_ready"}, {in_ready0, in_ready1}, 2'b11);
    chk({tag, ".hs_valid"}, {out_valid0, out_valid1}, 2'b00);
    chk_res({tag, ".held"}, eq0, eq1, er, eovf, edz);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int unsigned bb, sel;
    logic [23:0] rp;
    logic [15:0] rb;

    #1 rst_n = 1'b0;
    #2;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("div5_half",   24'h050000, 16'h8000, 0);
    run_op("max_exact",   24'hFEFF01, 16'hFFFF, 0);
    run_op("rem1",        24'h050001, 16'h8000, 0);
    run_op("ovf",         24'h800000, 16'h8000, 0);
    run_op("ovf_edge",    24'h800000, 16'h8000 + 16'h0, 0);
    run_op("below_ovf",   24'h7FFFFF, 16'h8000, 0);
    run_op("dz",          24'h123456, 16'h0000, 0);
    run_op("round",       24'h04C000, 16'h8000, 0);
    run_op("round_sat",   24'hFF7F00, 16'hFFFF, 0);
    run_op("zero_p",      24'h000000, 16'h0001, 0);
    run_op("backpress",   24'h0A1234, 16'h4321, 5);

    // Reset pulse inside the fourth CALC cycle.
    @(negedge clk);
    in_p = 24'h050000; in_b = 16'h8000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 24'h050000, 16'h8000, 0);

    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      bb  = int'(rb);
      if (sel == 1 || bb == 0) rp = 24'($urandom);
      else                     rp = 24'($urandom % (bb * 256));
      run_op("random", rp, rb, (sel == 2) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
